// File: rtl/lut_pattern_table_if.sv
`default_nettype none
// ============================================================================
//  Module      : lut_pattern_table_if
//  Description : Bus bundle for lut_pattern_table. It carries the 4-bit
//                lookup address (a3..a0) from the consumer and the exported
//                16-entry table (RAM) back to the consumer.
//                  slave  : the table side (address in, RAM out)
//                  master : the consumer side (address out, RAM in)
//  Revision    : 1.0  initial release
// ============================================================================
interface lut_pattern_table_if;
  logic        a0;   // address bit 0 (LSB)
  logic        a1;   // address bit 1
  logic        a2;   // address bit 2
  logic        a3;   // address bit 3 (MSB)
  logic [15:0] RAM;  // current table contents, entry n is RAM[n]

  modport slave  (input  a0, a1, a2, a3, output RAM);
  modport master (output a0, a1, a2, a3, input  RAM);
endinterface
`default_nettype wire

// File: rtl/lut_pattern_table.sv
`default_nettype none
// ============================================================================
//  Module      : lut_pattern_table
//  Description : Sixteen-entry, 1-bit-wide lookup table holding a rotating
//                bit pattern. The table clears while rst is low. The first
//                clock after release loads SEED, and every later clock
//                rotates the table left by one entry (entry 0 takes entry 15).
//  Ports       : clk  - rising-edge clock
//                rst  - asynchronous, active-low reset
//                bus  - slave side of lut_pattern_table_if
//                       (a3..a0 lookup address in, RAM[15:0] table out)
//  Parameters  : SEED - pattern loaded on the first clock after reset release
//  Revision    : 1.0  initial release
// ============================================================================
module lut_pattern_table #(
  parameter logic [15:0] SEED = 16'h012C
) (
  input  wire                  clk,
  input  wire                  rst,
  lut_pattern_table_if.slave   bus
);

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_ram;
  logic [15:0] w_ram_next;

  // Table and state register. Reset clears the table immediately, which
  // also discards the rotation phase so the next release restarts at SEED.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= CLEAR;
      r_ram   <= 16'h0000;
    end else begin
      r_state <= w_state_next;
      r_ram   <= w_ram_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_ram_next   = r_ram;
    case (r_state)
      CLEAR: begin
        w_ram_next   = SEED;
        w_state_next = RUN;
      end
      RUN: begin
        w_ram_next = {r_ram[14:0], r_ram[15]};
      end
      default: begin
        w_state_next = CLEAR;
        w_ram_next   = 16'h0000;
      end
    endcase
  end

  // The address travels with the table; the consumer selects
  // RAM[{a3,a2,a1,a0}] itself, so the address never touches the storage.
  assign bus.RAM = r_ram;

endmodule
`default_nettype wire

// File: tb/tb_lut_pattern_table.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lut_pattern_table
//  Description : Directed self-checking bench for lut_pattern_table. A second
//                instance seeded with 16'h8000 exercises the bit-15 to bit-0
//                wrap of the rotate.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_lut_pattern_table;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  lut_pattern_table_if u_if ();
  lut_pattern_table_if u_if_wrap ();

  lut_pattern_table #(.SEED(16'h012C)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  lut_pattern_table #(.SEED(16'h8000)) u_dut_wrap (
    .clk (clk),
    .rst (rst),
    .bus (u_if_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] observed,
                       input logic [15:0] expected);
    n_checks++;
    if (observed === expected) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, observed, expected);
  endtask

  task automatic set_addr(input logic [3:0] addr);
    {u_if.a3, u_if.a2, u_if.a1, u_if.a0} = addr;
    {u_if_wrap.a3, u_if_wrap.a2, u_if_wrap.a1, u_if_wrap.a0} = addr;
  endtask

  // Looked-up bit at a given address, as seen by a consumer.
  task automatic check_bit(input string tag, input logic [3:0] addr,
                           input logic expected);
    set_addr(addr);
    #1;
    check(tag, {15'h0, u_if.RAM[{u_if.a3, u_if.a2, u_if.a1, u_if.a0}]},
          {15'h0, expected});
  endtask

  // One rising edge, outputs sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Release reset between edges (on the falling edge side).
  task automatic release_rst();
    @(negedge clk);
    #2;
    rst = 1'b1;
  endtask

  logic [15:0] exp_seq [4];

  initial begin
    n_checks = 0;
    n_pass   = 0;
    exp_seq[0] = 16'h012C;
    exp_seq[1] = 16'h0258;
    exp_seq[2] = 16'h04B0;
    exp_seq[3] = 16'h0960;
    rst = 1'b0;
    set_addr(4'd0);

    // Reset hold: clocks have no effect, every looked-up bit is 0.
    repeat (3) tick();
    check("reset_ram", u_if.RAM, 16'h0000);
    check("reset_ram_wrap", u_if_wrap.RAM, 16'h0000);
    for (int i = 0; i < 16; i++) begin
      check_bit($sformatf("reset_bit%0d", i), i[3:0], 1'b0);
      #1;
    end

    // Seed load and rotation sequence.
    release_rst();
    #1;
    check("pre_edge_ram", u_if.RAM, 16'h0000);
    tick();
    check("seed_ram", u_if.RAM, 16'h012C);
    check_bit("seed_a3", 4'd3, 1'b1);
    check_bit("seed_a10", 4'd10, 1'b0);
    check_bit("seed_a4", 4'd4, 1'b0);
    check("wrap_seed", u_if_wrap.RAM, 16'h8000);
    tick();
    check("edge2_ram", u_if.RAM, 16'h0258);
    check_bit("edge2_a3", 4'd3, 1'b1);
    check("wrap_b15_to_b0", u_if_wrap.RAM, 16'h0001);
    tick();
    check("edge3_ram", u_if.RAM, 16'h04B0);
    check_bit("edge3_a10", 4'd10, 1'b1);
    check_bit("edge3_a7", 4'd7, 1'b1);
    tick();
    check("edge4_ram", u_if.RAM, 16'h0960);
    check_bit("edge4_a7", 4'd7, 1'b0);

    // Wrap: 16 edges after load returns to the seed (3 rotates done so far).
    repeat (13) tick();
    check("wrap16_ram", u_if.RAM, 16'h012C);
    check("wrap16_ram_wrap", u_if_wrap.RAM, 16'h8000);

    // Async reset mid-run: clears before the next edge.
    tick();
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("async_clr_ram", u_if.RAM, 16'h0000);
    check("async_clr_ram_wrap", u_if_wrap.RAM, 16'h0000);
    tick();
    check("held_clr_ram", u_if.RAM, 16'h0000);
    release_rst();
    tick();
    check("rerelease_seed", u_if.RAM, 16'h012C);

    // Address independence: scramble the address every half cycle.
    @(negedge clk);
    rst = 1'b0;
    #1;
    release_rst();
    for (int k = 0; k < 4; k++) begin
      set_addr(4'($urandom_range(0, 15)));
      @(posedge clk);
      #1;
      check($sformatf("scramble_ram%0d", k), u_if.RAM, exp_seq[k]);
      set_addr(4'($urandom_range(0, 15)));
      @(negedge clk);
      #1;
      check($sformatf("scramble_half%0d", k), u_if.RAM, exp_seq[k]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
